ulpb_tx_sched: RTL
==================

ULPB_TX_SCHED -- requirements
Module: ulpb_tx_sched

Shares one ULPB bus-node transmit port between NUM_REQ local requesters. Selection is priority-first, then round-robin. Includes retry, backoff and timeout.

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters.
REQ-002 Parameter ADDR_W, default 8: bus address width.
REQ-003 Parameter DATA_W, default 32: payload width.
REQ-004 Parameter MAX_RETRY, default 2: retries allowed after TX_FAIL.
REQ-005 Parameter BACKOFF_CYCLES, default 4: TX_REQ low time between retries.
REQ-006 Parameter TIMEOUT_CYCLES, default 255: maximum cycles in WAIT per attempt.
REQ-007 Port CLK_EXT  in  1: the single clock; all logic is on its rising edge.
REQ-008 Port RESET  in  1: synchronous, active-high reset.
REQ-009 Port REQ  in  NUM_REQ: per-requester transmit request, level.
REQ-010 Port PRIO  in  NUM_REQ: per-requester priority flag.
REQ-011 Port ADDR  in  NUM_REQ*ADDR_W: flattened addresses; requester i is at [i*ADDR_W +: ADDR_W].
REQ-012 Port DATA  in  NUM_REQ*DATA_W: flattened payloads, same slicing as ADDR.
REQ-013 Port ACK  out  NUM_REQ: one-cycle success pulse to the granted requester.
REQ-014 Port FAIL  out  NUM_REQ: one-cycle failure pulse to the granted requester.
REQ-015 Port TX_REQ  out  1: request to the bus node.
REQ-016 Port TX_ADDR, TX_DATA  out  ADDR_W, DATA_W: latched winner's address and payload.
REQ-017 Port TX_PRIORITY  out  1: latched winner's PRIO.
REQ-018 Port TX_ACK, TX_FAIL  in  1: bus node completion pulses.
REQ-019 Port BUSY  out  1: high whenever the state is not IDLE.
REQ-020 Port GRANT_IDX  out  log2(NUM_REQ): index of the current winner.

Function
REQ-021 States SHALL be IDLE, WAIT, BACKOFF, DONE; all outputs SHALL be registered.
REQ-022 In IDLE with any REQ high, the winner SHALL be chosen as follows:
- Candidate set: requesters with REQ & PRIO, if any exist; otherwise all requesters with REQ.
- Within the set: round-robin, starting at index rr_ptr+1 (mod NUM_REQ).
REQ-023 On selection the block SHALL latch the winner's index, ADDR, DATA and PRIO, clear retry_cnt and the timeout counter, and enter WAIT. TX_REQ SHALL be high on the cycle after REQ was sampled.
REQ-024 In WAIT, TX_REQ SHALL stay high and TX_ADDR/TX_DATA/TX_PRIORITY SHALL stay stable; changes on REQ/ADDR/DATA SHALL be ignored until DONE.
REQ-025 TX_ACK in WAIT SHALL cause the following on the next cycle, then entry to DONE:
- ACK[winner] pulses for one cycle;
- TX_REQ goes low;
- rr_ptr is set to the winner's index.
REQ-026 TX_FAIL in WAIT, with retry_cnt < MAX_RETRY, SHALL increment retry_cnt, drop TX_REQ and enter BACKOFF.
REQ-027 TX_FAIL in WAIT, with retry_cnt == MAX_RETRY, SHALL pulse FAIL[winner], drop TX_REQ, set rr_ptr to the winner's index and enter DONE.
REQ-028 BACKOFF SHALL hold TX_REQ low for exactly BACKOFF_CYCLES cycles, then return to WAIT with TX_REQ high and the timeout counter cleared.
REQ-029 If the timeout counter reaches TIMEOUT_CYCLES in WAIT, the block SHALL pulse FAIL[winner], drop TX_REQ and enter DONE. There SHALL be no retry after a timeout.
REQ-030 Simultaneous events:
- TX_ACK and TX_FAIL in the same cycle: treated as ACK.
- TX_ACK and timeout in the same cycle: treated as ACK.
REQ-031 TX_ACK/TX_FAIL outside WAIT SHALL be ignored.
REQ-032 DONE SHALL last exactly one cycle with TX_REQ low, then go to IDLE. No arbitration occurs in DONE, so the requester has one cycle to drop REQ.
REQ-033 At most one bit of ACK|FAIL SHALL be high in any cycle.
REQ-034 rr_ptr SHALL wrap from NUM_REQ-1 to 0. The timeout counter and retry_cnt SHALL saturate and never wrap.

Reset
REQ-035 While RESET is high at a rising CLK_EXT edge, the block SHALL take these values, overriding any in-flight transaction without emitting an ACK or FAIL pulse:
- state = IDLE;
- TX_REQ = ACK = FAIL = BUSY = 0;
- TX_ADDR = TX_DATA = TX_PRIORITY = GRANT_IDX = 0;
- rr_ptr = NUM_REQ-1, so requester 0 is favoured first;
- retry_cnt and all counters = 0.

Structure
REQ-036 State encodings and default parameter values SHALL live in shared package ulpb_pkg.
REQ-037 The combinational priority/round-robin winner selection SHALL be sub-module ulpb_rr_pick (inputs: req, prio, rr_ptr; outputs: valid, idx).

Verification
REQ-038 Contention: REQ=4'b0110, PRIO=0 after reset -> winner 1. After TX_ACK, ACK=4'b0010 for one cycle; with REQ[1] dropped, the next winner is 2.
REQ-039 Priority: REQ=4'b1011, PRIO=4'b1000 -> GRANT_IDX=3 and TX_PRIORITY=1, irrespective of rr_ptr.
REQ-040 Retry: winner 0 receives TX_FAIL three times -> two BACKOFF gaps of 4 low cycles each, then FAIL=4'b0001 after the third TX_FAIL.
REQ-041 Timeout: no response for 255 WAIT cycles -> FAIL pulse for the winner, TX_REQ low, no retry.
REQ-042 Corner cases:
- TX_ACK and TX_FAIL in the same cycle -> ACK pulse only.
- RESET asserted mid-WAIT -> next cycle TX_REQ=0 and BUSY=0, with no ACK/FAIL pulse.

Source files
------------

// File: rtl/ulpb_pkg.sv
// Shared definitions for the ULPB transmit scheduler: FSM encoding, default
// parameter values and a width helper.
package ulpb_pkg;

    localparam int unsigned NUM_REQ_DEF        = 4;
    localparam int unsigned ADDR_W_DEF         = 8;
    localparam int unsigned DATA_W_DEF         = 32;
    localparam int unsigned MAX_RETRY_DEF      = 2;
    localparam int unsigned BACKOFF_CYCLES_DEF = 4;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWait    = 2'd1,
        StBackoff = 2'd2,
        StDone    = 2'd3
    } ulpb_state_e;

    // Index width that stays at least one bit wide for degenerate sizes.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ulpb_rr_pick.sv
// Combinational winner selection: priority requesters first, then round-robin
// starting one past rr_ptr.
module ulpb_rr_pick
    import ulpb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF
) (
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            prio,
    input  logic [idx_width(NUM_REQ)-1:0] rr_ptr,
    output logic                          valid,
    output logic [idx_width(NUM_REQ)-1:0] idx
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0] cand;
    logic               found;
    int unsigned        pos;

    always_comb begin
        cand  = req & prio;
        if (cand == '0) begin
            cand = req;
        end
        valid = |cand;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        // Scan rr_ptr+1 .. rr_ptr+NUM_REQ so the last winner is visited last.
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            pos = (32'(rr_ptr) + off) % NUM_REQ;
            if (!found && cand[IDX_W'(pos)]) begin
                found = 1'b1;
                idx   = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/ulpb_tx_sched.sv
// Shares one ULPB transmit port between NUM_REQ requesters with retry,
// backoff and per-attempt timeout. All outputs are registered.
module ulpb_tx_sched
    import ulpb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = NUM_REQ_DEF,
    parameter int unsigned ADDR_W         = ADDR_W_DEF,
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned MAX_RETRY      = MAX_RETRY_DEF,
    parameter int unsigned BACKOFF_CYCLES = BACKOFF_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                          CLK_EXT,
    input  logic                          RESET,
    input  logic [NUM_REQ-1:0]            REQ,
    input  logic [NUM_REQ-1:0]            PRIO,
    input  logic [NUM_REQ*ADDR_W-1:0]     ADDR,
    input  logic [NUM_REQ*DATA_W-1:0]     DATA,
    output logic [NUM_REQ-1:0]            ACK,
    output logic [NUM_REQ-1:0]            FAIL,
    output logic                          TX_REQ,
    output logic [ADDR_W-1:0]             TX_ADDR,
    output logic [DATA_W-1:0]             TX_DATA,
    output logic                          TX_PRIORITY,
    input  logic                          TX_ACK,
    input  logic                          TX_FAIL,
    output logic                          BUSY,
    output logic [idx_width(NUM_REQ)-1:0] GRANT_IDX
);

    localparam int unsigned IDX_W   = idx_width(NUM_REQ);
    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 2);
    localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned BO_W    = $clog2(BACKOFF_CYCLES + 1);

    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [TMO_W-1:0]   TMO_SAT   = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BO_W-1:0]    BO_LAST   = BO_W'(BACKOFF_CYCLES - 1);

    ulpb_state_e          state_q, state_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]     rr_q, rr_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 prio_q, prio_d;
    logic                 tx_req_q, tx_req_d;
    logic                 busy_q, busy_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [NUM_REQ-1:0]   fail_q, fail_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [BO_W-1:0]      bo_q, bo_d;

    logic                 pick_valid;
    logic [IDX_W-1:0]     pick_idx;
    logic [ADDR_W-1:0]    addr_arr [NUM_REQ];
    logic [DATA_W-1:0]    data_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i] = ADDR[i*ADDR_W +: ADDR_W];
        assign data_arr[i] = DATA[i*DATA_W +: DATA_W];
    end

    ulpb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (REQ),
        .prio   (PRIO),
        .rr_ptr (rr_q),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        addr_d   = addr_q;
        data_d   = data_q;
        prio_d   = prio_q;
        tx_req_d = tx_req_q;
        ack_d    = '0;
        fail_d   = '0;
        retry_d  = retry_q;
        tmo_d    = tmo_q;
        bo_d     = bo_q;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    grant_d  = pick_idx;
                    addr_d   = addr_arr[pick_idx];
                    data_d   = data_arr[pick_idx];
                    prio_d   = PRIO[pick_idx];
                    retry_d  = '0;
                    tmo_d    = '0;
                    tx_req_d = 1'b1;
                    state_d  = StWait;
                end
            end
            StWait: begin
                // ACK outranks both a concurrent TX_FAIL and a concurrent timeout.
                if (TX_ACK) begin
                    ack_d[grant_q] = 1'b1;
                    tx_req_d       = 1'b0;
                    rr_d           = grant_q;
                    state_d        = StDone;
                end else if (TX_FAIL) begin
                    tx_req_d = 1'b0;
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        bo_d    = '0;
                        state_d = StBackoff;
                    end else begin
                        fail_d[grant_q] = 1'b1;
                        rr_d            = grant_q;
                        state_d         = StDone;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // This edge closes the TIMEOUT_CYCLES-th WAIT cycle.
                    fail_d[grant_q] = 1'b1;
                    tx_req_d        = 1'b0;
                    rr_d            = grant_q;
                    state_d         = StDone;
                end else if (tmo_q != TMO_SAT) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StBackoff: begin
                if (bo_q == BO_LAST) begin
                    tmo_d    = '0;
                    tx_req_d = 1'b1;
                    state_d  = StWait;
                end else begin
                    bo_d = bo_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge CLK_EXT) begin
        if (RESET) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_q     <= IDX_W'(NUM_REQ - 1);
            addr_q   <= '0;
            data_q   <= '0;
            prio_q   <= 1'b0;
            tx_req_q <= 1'b0;
            busy_q   <= 1'b0;
            ack_q    <= '0;
            fail_q   <= '0;
            retry_q  <= '0;
            tmo_q    <= '0;
            bo_q     <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            prio_q   <= prio_d;
            tx_req_q <= tx_req_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
            fail_q   <= fail_d;
            retry_q  <= retry_d;
            tmo_q    <= tmo_d;
            bo_q     <= bo_d;
        end
    end

    assign ACK         = ack_q;
    assign FAIL        = fail_q;
    assign TX_REQ      = tx_req_q;
    assign TX_ADDR     = addr_q;
    assign TX_DATA     = data_q;
    assign TX_PRIORITY = prio_q;
    assign BUSY        = busy_q;
    assign GRANT_IDX   = grant_q;

endmodule
